start_token_srl_fifo: RTL and testbench
=======================================

Name: start_token_srl_fifo

Overview:
- Complete HLS-style start/stream FIFO: write handshake, read handshake, occupancy tracking and read addressing, built around an internal SRL (shift-register) storage array.
- The write side shifts words in at index 0. The read side selects the oldest word by index.
- Sits between a producer process (e.g. the Linear_Layer loader) and a consumer PE, and carries start tokens or narrow data words.

Parameters:
- DATA_WIDTH, 1, width of each stored word.
- ADDR_WIDTH, 1, read-index width. Must equal clog2(DEPTH).
- DEPTH, 2, number of storage entries. Minimum 2.

Ports:
- ap_clk  input  1  clock; all state updates on the rising edge.
- ap_rst_n  input  1  asynchronous active-low reset.
- if_din  input  DATA_WIDTH  write data.
- if_write_ce  input  1  write clock-enable.
- if_write  input  1  write request.
- if_full_n  output  1  registered; 1 = can accept a word.
- if_dout  output  DATA_WIDTH  oldest stored word. Valid only while if_empty_n=1.
- if_read_ce  input  1  read clock-enable.
- if_read  input  1  read request; acknowledges the current if_dout.
- if_empty_n  output  1  registered; 1 = if_dout holds valid data.
- occupancy  output  ADDR_WIDTH+1  registered count of stored words, 0..DEPTH.

Behaviour:
- Handshake terms:
  - push = if_write & if_write_ce & if_full_n.
  - pop = if_read & if_read_ce & if_empty_n.
  - A request while the FIFO is full (for writes) or empty (for reads) is ignored. No state change, no error flag.
- Storage: on push, entry[i+1] <= entry[i] for i = 0..DEPTH-2, and entry[0] <= if_din. Storage is never reset and does not shift without a push.
- Read index: rd_addr = occupancy-1 when occupancy>0, else 0. The index is derived from the registered count. if_dout = entry[rd_addr], combinational from storage and the registered index.
- Occupancy update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged. The shift moves the next-oldest word into the popped index.
  - neither: unchanged.
- Flags, computed from next_occupancy:
  - if_empty_n <= (next_occupancy != 0).
  - if_full_n <= (next_occupancy != DEPTH).
- Latency:
  - A word pushed in cycle N appears on if_dout, with if_empty_n=1 (if the FIFO was empty), from cycle N+1.
  - A pop in cycle N frees space: if_full_n rises in cycle N+1.
  - There is no combinational path from if_write or if_read to either flag.
- Boundary conditions:
  - Full (occupancy=DEPTH): a push is blocked even if a pop occurs in the same cycle. The result is pop-only and occupancy becomes DEPTH-1.
  - Empty: a pop is blocked. A simultaneous push gives push-only.
  - At occupancy=1, simultaneous push and pop keeps occupancy at 1 with if_empty_n held at 1. The new word appears on if_dout in the next cycle.
  - CE low masks the corresponding request entirely.
- Reset: asserting ap_rst_n=0 at any time, including mid-transfer, immediately gives:
  - occupancy=0, if_empty_n=0, if_full_n=1.
  - Stored words are discarded logically; storage contents are retained but unaddressed.
  - Operation resumes on the first clock edge after deassertion.
- if_dout when empty is don't-care. The bench must not check it.
- Implementation size: storage, counter and flag logic, 120-200 lines RTL.

Test Plan:
- Reset/idle: hold ap_rst_n=0 for 3 cycles, then release with no requests -> if_empty_n=0, if_full_n=1, occupancy=0, stable for 10 cycles.
- Fill/drain, DEPTH=4, DATA_WIDTH=8:
  - push 0x11,0x22,0x33,0x44 on consecutive cycles -> if_full_n=0 after the 4th, occupancy=4.
  - extra push of 0x55 ignored.
  - pop 4 times -> if_dout sequence 0x11,0x22,0x33,0x44, then if_empty_n=0.
- Simultaneous push/pop at occupancy=2 (holding 0xA1,0xA2), pushing 0xA3 for 5 cycles while popping -> occupancy stays 2; if_dout sequence 0xA1,0xA2,0xA3,0xA3,0xA3.
- Full with both requests: at occupancy=4, assert write (0x99) and read together -> pop only; occupancy=3; if_full_n=1 next cycle; 0x99 never appears.
- CE masking: if_write=1 with if_write_ce=0 for 3 cycles, then if_read=1 with if_read_ce=0 -> occupancy unchanged and no data movement.
- Reset mid-operation: at occupancy=3, drop ap_rst_n between clock edges -> flags reset immediately (asynchronously). After release, push 0x7E -> if_dout=0x7E next cycle, occupancy=1.

Source files
------------

// File: rtl/start_token_srl_fifo.sv
`default_nettype none
// ============================================================================
// start_token_srl_fifo : shift-register FIFO for start tokens / narrow words,
//                        registered full/empty flags and occupancy count.
// Revision 1.0
// ============================================================================
module start_token_srl_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   occupancy
);

    localparam logic [ADDR_WIDTH:0]   c_depth  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_one    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_one_a  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_occ;
    logic [ADDR_WIDTH:0]   w_occ_next;
    logic                  r_empty_n;
    logic                  r_full_n;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    assign w_push = if_write & if_write_ce & r_full_n;
    assign w_pop  = if_read  & if_read_ce  & r_empty_n;

    always_comb begin
        w_occ_next = r_occ;
        if (w_push && !w_pop) begin
            w_occ_next = r_occ + c_one;
        end else if (w_pop && !w_push) begin
            w_occ_next = r_occ - c_one;
        end
    end

    // Flags are registered from the next count, so requests never reach them combinationally.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_occ     <= '0;
            r_empty_n <= 1'b0;
            r_full_n  <= 1'b1;
        end else begin
            r_occ     <= w_occ_next;
            r_empty_n <= (w_occ_next != '0);
            r_full_n  <= (w_occ_next != c_depth);
        end
    end

    // Storage has no reset: after reset the count alone marks it as empty.
    always_ff @(posedge ap_clk) begin
        if (w_push) begin
            for (int i = DEPTH-1; i > 0; i--) begin
                r_mem[i] <= r_mem[i-1];
            end
            r_mem[0] <= if_din;
        end
    end

    // Oldest word sits at index count-1; the wrap at count==2^ADDR_WIDTH is intended.
    assign w_rd_addr = (r_occ == '0) ? '0 : (r_occ[ADDR_WIDTH-1:0] - c_one_a);

    assign if_dout    = r_mem[w_rd_addr];
    assign if_empty_n = r_empty_n;
    assign if_full_n  = r_full_n;
    assign occupancy  = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_start_token_srl_fifo.sv
`default_nettype none
// ============================================================================
// tb_start_token_srl_fifo : directed + random bench against a queue model.
// Revision 1.0
// ============================================================================
module tb_start_token_srl_fifo;

    localparam int c_dw    = 8;
    localparam int c_aw    = 2;
    localparam int c_depth = 4;

    logic            ap_clk;
    logic            ap_rst_n;
    logic [c_dw-1:0] if_din;
    logic            if_write_ce;
    logic            if_write;
    logic            if_full_n;
    logic [c_dw-1:0] if_dout;
    logic            if_read_ce;
    logic            if_read;
    logic            if_empty_n;
    logic [c_aw:0]   occupancy;

    logic [c_dw-1:0] r_model_q[$];
    int              n_checks;
    int              n_errors;

    start_token_srl_fifo #(
        .DATA_WIDTH (c_dw),
        .ADDR_WIDTH (c_aw),
        .DEPTH      (c_depth)
    ) u_dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .if_din      (if_din),
        .if_write_ce (if_write_ce),
        .if_write    (if_write),
        .if_full_n   (if_full_n),
        .if_dout     (if_dout),
        .if_read_ce  (if_read_ce),
        .if_read     (if_read),
        .if_empty_n  (if_empty_n),
        .occupancy   (occupancy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".occ"},     32'(occupancy),  32'(r_model_q.size()));
        chk({tag, ".empty_n"}, 32'(if_empty_n), 32'(r_model_q.size() != 0));
        chk({tag, ".full_n"},  32'(if_full_n),  32'(r_model_q.size() != c_depth));
        if (r_model_q.size() != 0) begin
            chk({tag, ".dout"}, 32'(if_dout), 32'(r_model_q[0]));
        end
    endtask

    // One clock: drive requests, let the edge happen, update the model, compare.
    task automatic step(input string tag, input logic w, input logic wce,
                        input logic r, input logic rce, input logic [c_dw-1:0] d);
        bit do_push;
        bit do_pop;
        if_write    = w;
        if_write_ce = wce;
        if_read     = r;
        if_read_ce  = rce;
        if_din      = d;
        do_push = w && wce && (r_model_q.size() < c_depth);
        do_pop  = r && rce && (r_model_q.size() > 0);
        @(posedge ap_clk);
        if (do_pop)  void'(r_model_q.pop_front());
        if (do_push) r_model_q.push_back(d);
        #1;
        check_state(tag);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        ap_rst_n    = 1'b0;
        if_din      = '0;
        if_write    = 1'b0;
        if_write_ce = 1'b0;
        if_read     = 1'b0;
        if_read_ce  = 1'b0;

        // Reset and idle
        repeat (3) @(posedge ap_clk);
        #1;
        check_state("in_reset");
        ap_rst_n = 1'b1;
        repeat (10) step("idle", 0, 0, 0, 0, 8'h00);

        // Fill, blocked extra push, drain
        step("fill", 1, 1, 0, 0, 8'h11);
        step("fill", 1, 1, 0, 0, 8'h22);
        step("fill", 1, 1, 0, 0, 8'h33);
        step("fill", 1, 1, 0, 0, 8'h44);
        chk("full_after_fill", 32'(if_full_n), 32'd0);
        step("push_full", 1, 1, 0, 0, 8'h55);
        chk("occ_after_blocked", 32'(occupancy), 32'd4);
        repeat (4) step("drain", 0, 0, 1, 1, 8'h00);
        chk("empty_after_drain", 32'(if_empty_n), 32'd0);
        step("pop_empty", 0, 0, 1, 1, 8'h00);

        // Simultaneous push/pop at occupancy 2
        step("sim_pre", 1, 1, 0, 0, 8'hA1);
        step("sim_pre", 1, 1, 0, 0, 8'hA2);
        repeat (5) step("sim_pp", 1, 1, 1, 1, 8'hA3);
        chk("sim_occ", 32'(occupancy), 32'd2);
        repeat (2) step("sim_drain", 0, 0, 1, 1, 8'h00);

        // Push and pop together at occupancy 1
        step("one_pre", 1, 1, 0, 0, 8'h5A);
        step("one_pp", 1, 1, 1, 1, 8'hC3);
        chk("one_dout", 32'(if_dout), 32'hC3);
        step("one_drain", 0, 0, 1, 1, 8'h00);

        // Full with both requests: pop only, 0x99 dropped
        step("fb_pre", 1, 1, 0, 0, 8'hB1);
        step("fb_pre", 1, 1, 0, 0, 8'hB2);
        step("fb_pre", 1, 1, 0, 0, 8'hB3);
        step("fb_pre", 1, 1, 0, 0, 8'hB4);
        step("fb_both", 1, 1, 1, 1, 8'h99);
        chk("fb_occ", 32'(occupancy), 32'd3);
        repeat (3) step("fb_drain", 0, 0, 1, 1, 8'h00);

        // CE masking
        step("ce_pre", 1, 1, 0, 0, 8'hD1);
        step("ce_pre", 1, 1, 0, 0, 8'hD2);
        repeat (3) step("ce_w", 1, 0, 0, 0, 8'hEE);
        repeat (3) step("ce_r", 0, 0, 1, 0, 8'h00);
        chk("ce_dout", 32'(if_dout), 32'hD1);

        // Asynchronous reset mid-operation at occupancy 3
        step("rst_pre", 1, 1, 0, 0, 8'hD3);
        step("rst_idle", 0, 0, 0, 0, 8'h00);
        #2;
        ap_rst_n = 1'b0;
        #1;
        r_model_q.delete();
        check_state("async_rst");
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step("post_rst", 1, 1, 0, 0, 8'h7E);
        chk("post_rst_dout", 32'(if_dout), 32'h7E);
        chk("post_rst_occ", 32'(occupancy), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic w, wce, r, rce;
            w   = ($urandom_range(0, 99) < 60);
            wce = ($urandom_range(0, 99) < 85);
            r   = ($urandom_range(0, 99) < 55);
            rce = ($urandom_range(0, 99) < 85);
            step("rand", w, wce, r, rce, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
